load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the execute stage and the main memory block, directly upstream of memory.
- Accepts one load/store request at a time over a valid/ready handshake and converts the byte address to the memory's word index.
- Performs byte and halfword stores as read-modify-write on the 32-bit word memory.
- Extracts and sign/zero-extends load data, then returns a response over a valid/ready handshake.

Parameters:
- ADDR_WIDTH, 32, width of request address and memory address port.
- WORD_ADDRESSED, 1, 1: memAddress = reqAddr >> 2; 0: memAddress = reqAddr with bits [1:0] cleared.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- reqValid  in  1  request present.
- reqReady  out  1  unit can accept a request.
- reqWrite  in  1  1 = store, 0 = load.
- reqSize  in  2  0 = byte, 1 = halfword, 2 = word, 3 = treated as word.
- reqSigned  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- reqAddr  in  ADDR_WIDTH  byte address.
- reqData  in  32  store data, right-aligned.
- respValid  out  1  response present.
- respReady  in  1  consumer takes response.
- respData  out  32  load result; 0 for stores.
- respError  out  1  misaligned access (only with MISALIGN_TRAP_EN; tied 0 otherwise).
- memAddress  out  ADDR_WIDTH  to memory address.
- memReadEnable  out  1  to memory readEnable.
- memWriteEnable  out  1  to memory writeEnable.
- memDataIn  out  32  to memory dataIn.
- memDataOut  in  32  from memory dataOut (combinational read of memAddress).

Behaviour:
- States: IDLE, RD, WR, RSP.
- reqReady = (state == IDLE). A request is accepted when reqValid & reqReady at a rising edge; the address, size, signed flag and data are latched.
- Transitions from IDLE on accept:
  - load → RD.
  - word store → WR.
  - byte/half store → RD.
- RD: memReadEnable = 1, memWriteEnable = 0, memAddress = word address. At the end of the cycle memDataOut is captured.
  - For a load, the extracted value goes into respData and the state moves to RSP.
  - For a sub-word store, the merged word goes into the write buffer and the state moves to WR.
- WR: memWriteEnable = 1, memReadEnable = 0 (the memory only writes when readEnable is low), memDataIn = write buffer → RSP.
- RSP: respValid = 1, with respData held stable until respReady. On respValid & respReady → IDLE. No new request is accepted in the same cycle.
- Latency from accept edge to respValid high:
  - load: 2 cycles.
  - word store: 2 cycles.
  - sub-word store: 3 cycles.
- Byte lanes are little-endian: byte k occupies bits [8k+7:8k]. A halfword at offset 0 occupies [15:0]; at offset 2 it occupies [31:16].
- Merge rule: only the addressed lanes are replaced with the low bits of reqData; all other lanes keep the read value.
- Load extraction: the selected lane is shifted to bit 0, then sign-extended from bit 7/15 if reqSigned is set, otherwise zero-extended. Word loads ignore reqSigned.
- memAddress, memDataIn, memReadEnable and memWriteEnable are all 0 in IDLE and RSP.
- Reset values: state = IDLE, respValid = 0, respData = 0, respError = 0, all mem* outputs = 0, reqReady = 1 from the cycle after reset.
- Reset mid-operation: the transaction is aborted with no response. A write strobe already driven in the current cycle still lands at that edge; no strobe is asserted after it.
- Misalignment without the feature: a halfword uses addr[1] only, a word ignores addr[1:0] (access is aligned down).

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a halfword with addr[0] = 1, or a word with addr[1:0] != 0, goes IDLE → RSP directly with no memory access.
  - The response has respError = 1 and respData = 0.
  - Latency is 1 cycle.
  - respError = 0 on all aligned responses.
- Undefined: respError is tied 0 and the aligned-down rule applies.

Test Plan:
- Reset then idle: assert reset for 2 cycles → reqReady = 1, respValid = 0, all mem* outputs = 0.
- Word store then load: store 0xDEADBEEF to 0x10 → memWriteEnable pulses one cycle with memAddress = 0x4 and respValid at +2. Load word 0x10 → respData = 0xDEADBEEF at +2.
- Byte store RMW: word 0x11223344 at 0x20, store byte 0xAB to 0x22 → RD then WR, with memDataIn = 0x11AB3344 and respValid at +3.
- Signed/unsigned loads: word 0x80F0FF7F at 0x30.
  - Load byte at 0x30 signed → 0x0000007F.
  - Load byte at 0x31 signed → 0xFFFFFFFF.
  - Load half at 0x32 unsigned → 0x000080F0.
  - Load half at 0x32 signed → 0xFFFF80F0.
- Response backpressure: hold respReady = 0 for 5 cycles → respValid and respData stable, reqReady = 0. Then assert respReady → IDLE next cycle.
- Misaligned word load at 0x31:
  - With MISALIGN_TRAP_EN: respError = 1 at +1, no memReadEnable pulse.
  - Without: returns the word at 0x30.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between execute and a 32-bit word memory; optional MISALIGN_TRAP_EN traps misaligned accesses.
// Latency accept->respValid: load 2, word store 2, sub-word store (read-modify-write) 3, trapped access 1.
// Backpressure: one transaction in flight; reqReady only in IDLE, response held until respReady.
module load_store_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter bit WORD_ADDRESSED = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic                  reqWrite,
    input  logic [1:0]            reqSize,
    input  logic                  reqSigned,
    input  logic [ADDR_WIDTH-1:0] reqAddr,
    input  logic [31:0]           reqData,
    output logic                  respValid,
    input  logic                  respReady,
    output logic [31:0]           respData,
    output logic                  respError,
    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic                  memReadEnable,
    output logic                  memWriteEnable,
    output logic [31:0]           memDataIn,
    input  logic [31:0]           memDataOut
);

    typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

    state_t      state;
    logic        wr_q;
    logic        sgn_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic [31:0] data_q;

    logic [ADDR_WIDTH-1:0] word_addr;
    logic [1:0]            req_off;
    logic                  misaligned;
    logic [31:0]           shifted;
    logic [31:0]           lane_mask;
    logic [31:0]           load_val;
    logic [31:0]           merged;

    assign reqReady  = (state == IDLE);
    assign word_addr = WORD_ADDRESSED ? (reqAddr >> 2) : {reqAddr[ADDR_WIDTH-1:2], 2'b00};

    // Sub-word lanes are aligned down to their natural boundary.
    always_comb begin
        req_off = 2'd0;
        case (reqSize)
            2'd0:    req_off = reqAddr[1:0];
            2'd1:    req_off = {reqAddr[1], 1'b0};
            default: req_off = 2'd0;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    assign misaligned = ((reqSize == 2'd1) && reqAddr[0]) ||
                        (reqSize[1] && (reqAddr[1:0] != 2'd0));
`else
    assign misaligned = 1'b0;
`endif

    assign shifted = memDataOut >> {off_q, 3'b000};

    always_comb begin
        load_val  = memDataOut;
        lane_mask = 32'hFFFF_FFFF;
        case (size_q)
            2'd0: begin
                load_val  = {{24{sgn_q & shifted[7]}}, shifted[7:0]};
                lane_mask = 32'h0000_00FF << {off_q, 3'b000};
            end
            2'd1: begin
                load_val  = {{16{sgn_q & shifted[15]}}, shifted[15:0]};
                lane_mask = 32'h0000_FFFF << {off_q, 3'b000};
            end
            default: ;
        endcase
    end

    assign merged = (memDataOut & ~lane_mask) | ((data_q << {off_q, 3'b000}) & lane_mask);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            wr_q           <= 1'b0;
            sgn_q          <= 1'b0;
            size_q         <= 2'd0;
            off_q          <= 2'd0;
            data_q         <= 32'd0;
            respValid      <= 1'b0;
            respData       <= 32'd0;
            respError      <= 1'b0;
            memAddress     <= '0;
            memReadEnable  <= 1'b0;
            memWriteEnable <= 1'b0;
            memDataIn      <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (reqValid) begin
                        wr_q      <= reqWrite;
                        sgn_q     <= reqSigned;
                        size_q    <= reqSize;
                        off_q     <= req_off;
                        data_q    <= reqData;
                        respError <= misaligned;
                        if (misaligned) begin
                            respData  <= 32'd0;
                            respValid <= 1'b1;
                            state     <= RSP;
                        end else if (reqWrite && reqSize[1]) begin
                            memAddress     <= word_addr;
                            memWriteEnable <= 1'b1;
                            memDataIn      <= reqData;
                            state          <= WR;
                        end else begin
                            memAddress    <= word_addr;
                            memReadEnable <= 1'b1;
                            state         <= RD;
                        end
                    end
                end
                RD: begin
                    memReadEnable <= 1'b0;
                    if (wr_q) begin
                        memWriteEnable <= 1'b1;
                        memDataIn      <= merged;
                        state          <= WR;
                    end else begin
                        memAddress <= '0;
                        respData   <= load_val;
                        respValid  <= 1'b1;
                        state      <= RSP;
                    end
                end
                WR: begin
                    memWriteEnable <= 1'b0;
                    memAddress     <= '0;
                    memDataIn      <= 32'd0;
                    respData       <= 32'd0;
                    respValid      <= 1'b1;
                    state          <= RSP;
                end
                RSP: begin
                    if (respReady) begin
                        respValid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural word memory; honours MISALIGN_TRAP_EN.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqValid, reqReady, reqWrite, reqSigned;
    logic [1:0]  reqSize;
    logic [31:0] reqAddr, reqData;
    logic        respValid, respReady, respError;
    logic [31:0] respData;
    logic [31:0] memAddress, memDataIn, memDataOut;
    logic        memReadEnable, memWriteEnable;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .reset(reset),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
        .reqSize(reqSize), .reqSigned(reqSigned), .reqAddr(reqAddr), .reqData(reqData),
        .respValid(respValid), .respReady(respReady), .respData(respData), .respError(respError),
        .memAddress(memAddress), .memReadEnable(memReadEnable), .memWriteEnable(memWriteEnable),
        .memDataIn(memDataIn), .memDataOut(memDataOut)
    );

    logic [31:0] mem [0:255];
    assign memDataOut = mem[memAddress[7:0]];

    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] last_wr_addr = 32'd0;
    logic [31:0] last_wr_data = 32'd0;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
        end else if (memWriteEnable && !memReadEnable) begin
            mem[memAddress[7:0]] <= memDataIn;
        end
        if (memReadEnable) rd_cnt <= rd_cnt + 1;
        if (memWriteEnable) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= memAddress;
            last_wr_data <= memDataIn;
        end
    end

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] shadow [0:255];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        w = shadow[a[9:2]];
        b = w[8*a[1:0] +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        if (sz == 2'd0) return (sg && b[7]) ? {24'hFFFFFF, b} : {24'h0, b};
        if (sz == 2'd1) return (sg && h[15]) ? {16'hFFFF, h} : {16'h0, h};
        return w;
    endfunction

    task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] w;
        w = shadow[a[9:2]];
        if (sz == 2'd0)      w[8*a[1:0] +: 8] = d[7:0];
        else if (sz == 2'd1) w[16*a[1] +: 16] = d[15:0];
        else                 w = d;
        shadow[a[9:2]] = w;
    endtask

    // Drives one request, then pops the scoreboard entry and compares it with the response.
    task automatic run(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_data, input logic exp_err,
                       input int exp_lat, input string name);
        exp_t e;
        int   lat;
        sb.push_back('{exp_data, exp_err, exp_lat});
        @(negedge clk);
        reqValid = 1'b1; reqWrite = w; reqSize = sz; reqSigned = sg; reqAddr = a; reqData = d;
        @(posedge clk); #1;
        reqValid = 1'b0;
        if (w && !exp_err) model_store(sz, a, d);
        lat = 1;
        while (!respValid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        checks++;
        if (!respValid) begin
            errors++;
            $display("FAIL %s timeout: respValid=%b required 1", name, respValid);
            return;
        end
        checks++;
        if (lat !== e.lat) begin
            errors++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, e.lat);
        end
        checks++;
        if (respData !== e.data) begin
            errors++;
            $display("FAIL %s data: got %h required %h", name, respData, e.data);
        end
        checks++;
        if (respError !== e.err) begin
            errors++;
            $display("FAIL %s error: got %b required %b", name, respError, e.err);
        end
        if (respReady) begin
            @(posedge clk); #1;
            checks++;
            if (respValid !== 1'b0 || reqReady !== 1'b1) begin
                errors++;
                $display("FAIL %s release: respValid=%b reqReady=%b required 0/1", name, respValid, reqReady);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'd0; reqSigned = 1'b0;
        reqAddr = 32'd0; reqData = 32'd0; respReady = 1'b1;
        for (int i = 0; i < 256; i++) shadow[i] = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (reqReady !== 1'b1 || respValid !== 1'b0 || respData !== 32'd0 || respError !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp: rdy=%b vld=%b data=%h err=%b required 1/0/0/0",
                     reqReady, respValid, respData, respError);
        end
        checks++;
        if (memAddress !== 32'd0 || memReadEnable !== 1'b0 || memWriteEnable !== 1'b0 || memDataIn !== 32'd0) begin
            errors++;
            $display("FAIL reset_mem: addr=%h re=%b we=%b din=%h required all 0",
                     memAddress, memReadEnable, memWriteEnable, memDataIn);
        end
    endtask

    task automatic test_word_store_load();
        int rd0, wr0;
        rd0 = rd_cnt; wr0 = wr_cnt;
        run(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, 2, "word_store");
        checks++;
        if (wr_cnt - wr0 !== 1 || rd_cnt - rd0 !== 0 || last_wr_addr !== 32'h4 || last_wr_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL word_store_mem: writes=%0d reads=%0d addr=%h din=%h required 1/0/4/deadbeef",
                     wr_cnt - wr0, rd_cnt - rd0, last_wr_addr, last_wr_data);
        end
        run(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, 2, "word_load");
    endtask

    task automatic test_byte_rmw();
        int rd0, wr0;
        run(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 32'd0, 1'b0, 2, "preload_20");
        rd0 = rd_cnt; wr0 = wr_cnt;
        run(1'b1, 2'd0, 1'b0, 32'h22, 32'h000000AB, 32'd0, 1'b0, 3, "byte_store");
        checks++;
        if (rd_cnt - rd0 !== 1 || wr_cnt - wr0 !== 1 || last_wr_addr !== 32'h8 || last_wr_data !== 32'h11AB3344) begin
            errors++;
            $display("FAIL byte_rmw_mem: reads=%0d writes=%0d addr=%h din=%h required 1/1/8/11ab3344",
                     rd_cnt - rd0, wr_cnt - wr0, last_wr_addr, last_wr_data);
        end
        run(1'b1, 2'd1, 1'b0, 32'h22, 32'hFFFF5566, 32'd0, 1'b0, 3, "half_store_hi");
        run(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 32'h55663344, 1'b0, 2, "half_store_readback");
    endtask

    task automatic test_signed_loads();
        run(1'b1, 2'd2, 1'b0, 32'h30, 32'h80F0FF7F, 32'd0, 1'b0, 2, "preload_30");
        run(1'b0, 2'd0, 1'b1, 32'h30, 32'd0, 32'h0000007F, 1'b0, 2, "lb_30_s");
        run(1'b0, 2'd0, 1'b1, 32'h31, 32'd0, 32'hFFFFFFFF, 1'b0, 2, "lb_31_s");
        run(1'b0, 2'd0, 1'b0, 32'h31, 32'd0, 32'h000000FF, 1'b0, 2, "lb_31_u");
        run(1'b0, 2'd1, 1'b0, 32'h32, 32'd0, 32'h000080F0, 1'b0, 2, "lh_32_u");
        run(1'b0, 2'd1, 1'b1, 32'h32, 32'd0, 32'hFFFF80F0, 1'b0, 2, "lh_32_s");
        run(1'b0, 2'd1, 1'b1, 32'h30, 32'd0, 32'hFFFFFF7F, 1'b0, 2, "lh_30_s");
        run(1'b0, 2'd3, 1'b1, 32'h30, 32'd0, 32'h80F0FF7F, 1'b0, 2, "lw_size3");
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        respReady = 1'b0;
        run(1'b0, 2'd0, 1'b0, 32'h33, 32'd0, 32'h00000080, 1'b0, 2, "bp_load");
        held = respData;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (respValid !== 1'b1 || respData !== 32'h00000080 || reqReady !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: vld=%b data=%h rdy=%b required 1/00000080/0",
                         i, respValid, respData, reqReady);
            end
        end
        @(negedge clk);
        respReady = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (respValid !== 1'b0 || reqReady !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: vld=%b rdy=%b required 0/1 (held %h)", respValid, reqReady, held);
        end
    endtask

    task automatic test_misaligned();
        int rd0;
        rd0 = rd_cnt;
`ifdef MISALIGN_TRAP_EN
        run(1'b0, 2'd2, 1'b0, 32'h31, 32'd0, 32'd0, 1'b1, 1, "misaligned_lw");
        checks++;
        if (rd_cnt - rd0 !== 0) begin
            errors++;
            $display("FAIL misaligned_noread: reads=%0d required 0", rd_cnt - rd0);
        end
        run(1'b0, 2'd1, 1'b0, 32'h33, 32'd0, 32'd0, 1'b1, 1, "misaligned_lh");
        run(1'b0, 2'd1, 1'b0, 32'h32, 32'd0, 32'h000080F0, 1'b0, 2, "aligned_after_trap");
`else
        run(1'b0, 2'd2, 1'b0, 32'h31, 32'd0, 32'h80F0FF7F, 1'b0, 2, "misaligned_lw");
        checks++;
        if (rd_cnt - rd0 !== 1) begin
            errors++;
            $display("FAIL misaligned_read: reads=%0d required 1", rd_cnt - rd0);
        end
        run(1'b0, 2'd1, 1'b0, 32'h33, 32'd0, 32'h000080F0, 1'b0, 2, "misaligned_lh");
`endif
    endtask

    task automatic test_reset_midop();
        int wr0;
        wr0 = wr_cnt;
        @(negedge clk);
        reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'd0; reqAddr = 32'h30; reqData = 32'h55;
        @(posedge clk); #1;
        reqValid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 256; i++) shadow[i] = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (respValid !== 1'b0 || reqReady !== 1'b1 || wr_cnt !== wr0 || memWriteEnable !== 1'b0) begin
            errors++;
            $display("FAIL reset_midop: vld=%b rdy=%b writes=%0d we=%b required 0/1/0/0",
                     respValid, reqReady, wr_cnt - wr0, memWriteEnable);
        end
    endtask

    task automatic test_random();
        logic        w, sg;
        logic [1:0]  sz;
        logic [31:0] a, d, exp_d;
        int          lat;
        for (int n = 0; n < 30; n++) begin
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            a  = 32'h40 + 32'($urandom_range(0, 63));
            d  = $urandom;
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz[1])      a[1:0] = 2'b00;
            exp_d = w ? 32'd0 : model_load(sz, sg, a);
            lat   = (w && !sz[1]) ? 3 : 2;
            run(w, sz, sg, a, d, exp_d, 1'b0, lat, "random");
        end
    endtask

    initial begin
        test_reset();
        test_word_store_load();
        test_byte_rmw();
        test_signed_loads();
        test_backpressure();
        test_misaligned();
        test_reset_midop();
        test_random();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
